// File: rtl/uart_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// uart_cmd_arbiter
//
// Shares the single command port of the UART controller among NUM_REQ
// requesters. A grant drives UART_ENB/instruction/write_value for one cycle,
// the write-back byte is captured at the end of that cycle, and the result is
// returned with a one-cycle req_ack pulse. A blocking read first polls
// "available?" and only issues "read" when wb_data[0] reports data. After a
// failed poll, the requester is masked for POLL_GAP cycles so it does not
// monopolise the port.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   POLL_GAP  mask length after a failed blocking-read poll (0..255)
//
// Ports:
//   clock        system clock, all state changes on posedge
//   reset        synchronous, active-high
//   req_valid    [NUM_REQ]     request pending per requester
//   req_op       [2*NUM_REQ]   op per requester: 00 blocking read,
//                              01 available?, 10 non-blocking read, 11 write
//   req_wdata    [8*NUM_REQ]   write byte per requester
//   req_ack      [NUM_REQ]     one-cycle completion pulse
//   resp_data    [8]           result byte, valid while req_ack is high
//   busy                       high whenever the FSM is not in IDLE
//   UART_ENB                   command strobe to the UART controller
//   instruction  [3]           001 available?, 010 read, 011 write, 000 idle
//   write_value  [8]           byte for the write command
//   wb_flag                    controller write-back valid (not needed here)
//   wb_data      [8]           controller write-back data
//
// Configuration macro:
//   UART_ARB_FIXED_PRIO_EN  defined: lowest eligible index wins, with no
//                           round-robin pointer. Undefined (default):
//                           round-robin arbitration starting after the last
//                           serviced requester.
// -----------------------------------------------------------------------------
module uart_cmd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int POLL_GAP = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           resp_data,
  output logic                 busy,
  output logic                 UART_ENB,
  output logic [2:0]           instruction,
  output logic [7:0]           write_value,
  input  logic                 wb_flag,
  input  logic [7:0]           wb_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] INS_IDLE  = 3'b000;
  localparam logic [2:0] INS_AVAIL = 3'b001;
  localparam logic [2:0] INS_READ  = 3'b010;
  localparam logic [2:0] INS_WRITE = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ISSUE_RD
  } state_e;

  typedef enum logic [1:0] {
    OP_BRD   = 2'b00,
    OP_AVAIL = 2'b01,
    OP_NBRD  = 2'b10,
    OP_WR    = 2'b11
  } op_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  op_e                op_q, op_d;
  logic               uart_enb_q, uart_enb_d;
  logic [2:0]         instr_q, instr_d;
  logic [7:0]         wval_q, wval_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [7:0]         resp_q, resp_d;
  logic [7:0]         mask_q [NUM_REQ];
  logic [7:0]         mask_d [NUM_REQ];

  op_e                op_arr    [NUM_REQ];
  logic [7:0]         wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               any_eligible;
  logic [IDX_W-1:0]   win_idx;
  logic               cmd_done;

  // Every write-back is treated as a result, whether or not wb_flag is set.
  logic unused_wb_flag;
  assign unused_wb_flag = wb_flag;

  // The requester being acked this cycle is excluded so that a requester
  // that keeps req_valid high cannot be granted twice in a row.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i]    = op_e'(req_op[2*i +: 2]);
      wdata_arr[i] = req_wdata[8*i +: 8];
      eligible[i]  = req_valid[i] && (mask_q[i] == 8'd0) && !req_ack_q[i];
    end
  end

  assign any_eligible = |eligible;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Lowest eligible index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IDX_W'(i);
    end
  end

  logic unused_cmd_done;
  assign unused_cmd_done = cmd_done;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // The pointer remembers the last requester that used the port, whether
  // it completed or failed its poll.
  assign rr_ptr_d = cmd_done ? idx_q : rr_ptr_q;

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Search from rr_ptr+1 with wrap-around; the first eligible hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    cand    = '0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    uart_enb_d = 1'b0;
    instr_d    = INS_IDLE;
    wval_d     = 8'h00;
    req_ack_d  = '0;
    resp_d     = resp_q;
    cmd_done   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_d[i] = (mask_q[i] != 8'd0) ? mask_q[i] - 8'd1 : 8'd0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (any_eligible) begin
          state_d    = S_ISSUE;
          idx_d      = win_idx;
          op_d       = op_arr[win_idx];
          uart_enb_d = 1'b1;
          unique case (op_arr[win_idx])
            OP_BRD, OP_AVAIL: instr_d = INS_AVAIL;
            OP_NBRD:          instr_d = INS_READ;
            OP_WR: begin
              instr_d = INS_WRITE;
              wval_d  = wdata_arr[win_idx];
            end
            default:          instr_d = INS_IDLE;
          endcase
        end
      end

      S_ISSUE: begin
        if (op_q == OP_BRD) begin
          if (wb_data[0]) begin
            // Data present: the read follows immediately, so the strobe stays high.
            state_d    = S_ISSUE_RD;
            uart_enb_d = 1'b1;
            instr_d    = INS_READ;
          end else begin
            // No data: give the port away and hold this requester off.
            state_d        = S_IDLE;
            mask_d[idx_q]  = 8'(POLL_GAP);
            cmd_done       = 1'b1;
          end
        end else begin
          state_d          = S_IDLE;
          resp_d           = (op_q == OP_WR) ? 8'h00 : wb_data;
          req_ack_d[idx_q] = 1'b1;
          cmd_done         = 1'b1;
        end
      end

      S_ISSUE_RD: begin
        state_d          = S_IDLE;
        resp_d           = wb_data;
        req_ack_d[idx_q] = 1'b1;
        cmd_done         = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_q       <= OP_BRD;
      uart_enb_q <= 1'b0;
      instr_q    <= INS_IDLE;
      wval_q     <= 8'h00;
      req_ack_q  <= '0;
      resp_q     <= 8'h00;
      // NOTE: the mask counters form a small array that still needs a reset,
      // because a stale count would silently lock a requester out.
      mask_q     <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      uart_enb_q <= uart_enb_d;
      instr_q    <= instr_d;
      wval_q     <= wval_d;
      req_ack_q  <= req_ack_d;
      resp_q     <= resp_d;
      mask_q     <= mask_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign resp_data   = resp_q;
  assign busy        = (state_q != S_IDLE);
  assign UART_ENB    = uart_enb_q;
  assign instruction = instr_q;
  assign write_value = wval_q;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_arbiter
//
// Directed bench for uart_cmd_arbiter (NUM_REQ=4, POLL_GAP=8). A table of
// single-requester commands is applied and checked in a loop. Hand-written
// sequences then cover round-robin order, a failed blocking-read poll with
// masking, and reset in the middle of a command. A stub models the UART
// controller: on the negedge of a strobe cycle it answers on wb_data.
// Inputs are driven and outputs sampled on negedges.
// -----------------------------------------------------------------------------
module tb_uart_cmd_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [2*NUM_REQ-1:0] req_op = '0;
  logic [8*NUM_REQ-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           resp_data;
  logic                 busy;
  logic                 UART_ENB;
  logic [2:0]           instruction;
  logic [7:0]           write_value;
  logic                 wb_flag = 1'b0;
  logic [7:0]           wb_data = 8'h00;

  logic [7:0] stub_avail = 8'h00;
  logic [7:0] stub_read  = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_arbiter #(.NUM_REQ(NUM_REQ), .POLL_GAP(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .resp_data   (resp_data),
    .busy        (busy),
    .UART_ENB    (UART_ENB),
    .instruction (instruction),
    .write_value (write_value),
    .wb_flag     (wb_flag),
    .wb_data     (wb_data)
  );

  always #5 clock = ~clock;

  // Controller stub: acts on the negedge inside a strobe cycle.
  always @(negedge clock) begin
    if (UART_ENB) begin
      wb_flag = 1'b1;
      case (instruction)
        3'b001:  wb_data = stub_avail;
        3'b010:  wb_data = stub_read;
        3'b011:  wb_data = 8'hEE;
        default: wb_data = 8'h00;
      endcase
    end else begin
      wb_flag = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic int ack_index(input logic [NUM_REQ-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (a[i]) r = i;
    return r;
  endfunction

  typedef struct {
    string      name;
    int         idx;
    logic [1:0] op;
    logic [7:0] wdata;
    logic [7:0] s_avail;
    logic [7:0] s_read;
    logic [2:0] exp_instr;
    logic [7:0] exp_wval;
    logic [7:0] exp_resp;
  } vec_t;

  vec_t vecs [7];
  int   exp_rr [5];

  initial begin
    //          name        idx op     wdata  avail  read   instr   wval   resp
    vecs[0] = '{"wr_r0",     0, 2'b11, 8'h5A, 8'h00, 8'h00, 3'b011, 8'h5A, 8'h00};
    vecs[1] = '{"avail_r1",  1, 2'b01, 8'h00, 8'h01, 8'h00, 3'b001, 8'h00, 8'h01};
    vecs[2] = '{"nbrd_r3",   3, 2'b10, 8'h00, 8'h00, 8'hC3, 3'b010, 8'h00, 8'hC3};
    vecs[3] = '{"brd_r2",    2, 2'b00, 8'h00, 8'h01, 8'h41, 3'b001, 8'h00, 8'h41};
    vecs[4] = '{"wr_r1",     1, 2'b11, 8'hFF, 8'h00, 8'h00, 3'b011, 8'hFF, 8'h00};
    vecs[5] = '{"avail0_r0", 0, 2'b01, 8'h00, 8'h80, 8'h00, 3'b001, 8'h00, 8'h80};
    vecs[6] = '{"brd_r3",    3, 2'b00, 8'h00, 8'h03, 8'h00, 3'b001, 8'h00, 8'h00};

`ifdef UART_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 1, 0, 1, 0};
`else
    exp_rr = '{1, 2, 3, 0, 1};
`endif

    // ---- reset state ----
    @(negedge clock);
    @(negedge clock);
    check("rst_enb",   32'(UART_ENB),    32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_wval",  32'(write_value), 32'h0);
    check("rst_ack",   32'(req_ack),     32'h0);
    check("rst_resp",  32'(resp_data),   32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    reset = 1'b0;

    // ---- table-driven single commands ----
    for (int v = 0; v < 7; v++) begin
      stub_avail = vecs[v].s_avail;
      stub_read  = vecs[v].s_read;
      req_op[2*vecs[v].idx +: 2]    = vecs[v].op;
      req_wdata[8*vecs[v].idx +: 8] = vecs[v].wdata;
      req_valid[vecs[v].idx]        = 1'b1;
      @(negedge clock);
      check({vecs[v].name, "_enb"},   32'(UART_ENB),    32'h1);
      check({vecs[v].name, "_instr"}, 32'(instruction), 32'(vecs[v].exp_instr));
      check({vecs[v].name, "_wval"},  32'(write_value), 32'(vecs[v].exp_wval));
      check({vecs[v].name, "_busy"},  32'(busy),        32'h1);
      if (vecs[v].op == 2'b00) begin
        @(negedge clock);
        check({vecs[v].name, "_rd_enb"},   32'(UART_ENB),    32'h1);
        check({vecs[v].name, "_rd_instr"}, 32'(instruction), 32'h2);
        check({vecs[v].name, "_rd_noack"}, 32'(req_ack),     32'h0);
      end
      @(negedge clock);
      check({vecs[v].name, "_ack"},      32'(req_ack),     32'(1 << vecs[v].idx));
      check({vecs[v].name, "_resp"},     32'(resp_data),   32'(vecs[v].exp_resp));
      check({vecs[v].name, "_enb_off"},  32'(UART_ENB),    32'h0);
      check({vecs[v].name, "_ins_off"},  32'(instruction), 32'h0);
      check({vecs[v].name, "_wval_off"}, 32'(write_value), 32'h0);
      req_valid[vecs[v].idx] = 1'b0;
      @(negedge clock);
      check({vecs[v].name, "_ack_off"},  32'(req_ack),     32'h0);
      check({vecs[v].name, "_idle"},     32'(busy),        32'h0);
    end

    // ---- round-robin with all four requesters polling ----
    begin
      int n_acks, last_cyc, cyc, id;
      do_reset();
      stub_avail = 8'h01;
      req_op     = 8'b01_01_01_01;
      req_valid  = 4'hF;
      n_acks   = 0;
      last_cyc = 0;
      cyc      = 0;
      while (n_acks < 5 && cyc < 30) begin
        @(negedge clock);
        cyc++;
        if (req_ack != '0) begin
          id = ack_index(req_ack);
          check($sformatf("rr_onehot_%0d", n_acks), 32'($countones(req_ack)), 32'h1);
          check($sformatf("rr_grant_%0d", n_acks), 32'(id), 32'(exp_rr[n_acks]));
          if (n_acks > 0) check($sformatf("rr_gap_%0d", n_acks), 32'(cyc - last_cyc), 32'h2);
          last_cyc = cyc;
          n_acks++;
        end
      end
      check("rr_ack_count", 32'(n_acks), 32'h5);
      req_valid = '0;
    end

    // ---- blocking read without data, with a non-blocking read pending ----
    begin
      logic seen_ack1;
      do_reset();
      stub_avail = 8'h00;
      stub_read  = 8'h77;
      req_op     = 8'b10_00_00_00;
      req_valid  = 4'b1010;
      seen_ack1  = 1'b0;
      for (int c = 0; c <= 10; c++) begin
        @(negedge clock);
        seen_ack1 |= req_ack[1];
        case (c)
          0: begin
            check("poll_enb",   32'(UART_ENB),    32'h1);
            check("poll_instr", 32'(instruction), 32'h1);
          end
          1: begin
            check("poll_fail_enb", 32'(UART_ENB), 32'h0);
            check("poll_fail_ack", 32'(req_ack),  32'h0);
          end
          2: begin
            check("r3_enb",   32'(UART_ENB),    32'h1);
            check("r3_instr", 32'(instruction), 32'h2);
          end
          3: begin
            check("r3_ack",  32'(req_ack),   32'h8);
            check("r3_resp", 32'(resp_data), 32'h77);
            req_valid[3] = 1'b0;
          end
          10: begin
            check("repoll_enb",   32'(UART_ENB),    32'h1);
            check("repoll_instr", 32'(instruction), 32'h1);
          end
          default: check($sformatf("masked_c%0d", c), 32'(UART_ENB), 32'h0);
        endcase
      end
      check("poll_no_ack_r1", 32'(seen_ack1), 32'h0);
      req_valid = '0;
    end

    // ---- reset during ISSUE ----
    begin
      logic [NUM_REQ-1:0] ack_seen;
      do_reset();
      req_op[1:0]    = 2'b11;
      req_wdata[7:0] = 8'h33;
      req_valid[0]   = 1'b1;
      @(negedge clock);
      check("mid_issue_enb", 32'(UART_ENB), 32'h1);
      reset     = 1'b1;
      req_valid = '0;
      @(negedge clock);
      check("mid_rst_enb",   32'(UART_ENB),    32'h0);
      check("mid_rst_instr", 32'(instruction), 32'h0);
      check("mid_rst_ack",   32'(req_ack),     32'h0);
      check("mid_rst_busy",  32'(busy),        32'h0);
      reset    = 1'b0;
      ack_seen = '0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        ack_seen |= req_ack;
      end
      check("mid_rst_no_ack", 32'(ack_seen), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Shares the single command port of the UART controller (UART_ENB / instruction / write_value in, wb_flag / wb_data out) among NUM_REQ CPU-side requesters. It applies round-robin arbitration and drives each granted command as a one-cycle strobe. It captures the write-back result and returns it with a one-cycle acknowledge. It also sequences a blocking-read operation: it polls "is value available" and issues "read value" only once data exists, and throttles a requester's re-polling so the others keep access.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- POLL_GAP, 8, cycles a requester is masked after a failed blocking-read poll (0..255; 0 = no masking)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_op  in  2*NUM_REQ  op per requester, bits [2i+1:2i]: 00 blocking read, 01 available?, 10 non-blocking read, 11 write
- req_wdata  in  8*NUM_REQ  write byte per requester, bits [8i+7:8i]
- req_ack  out  NUM_REQ  one-cycle completion pulse for the granted requester
- resp_data  out  8  result byte, valid while req_ack is high
- busy  out  1  high in any state other than IDLE
- UART_ENB  out  1  command strobe to the UART controller
- instruction  out  3  001 available?, 010 read, 011 write, 000 idle
- write_value  out  8  byte for the write command
- wb_flag  in  1  controller write-back valid
- wb_data  in  8  controller write-back data

## Operation
- The reset values of all outputs are 0. This covers UART_ENB, instruction, write_value, req_ack, resp_data and busy. Reset also clears the RR pointer and all poll-mask counters. Reset mid-command abandons the command with no ack.
- A requester is eligible when req_valid[i]=1, mask_cnt[i]=0, and i is not the index being acked this cycle.
- States are IDLE, ISSUE, ISSUE_RD.
- IDLE:
  - If any requester is eligible, pick the winner, searching from rr_ptr+1 with wrap-around.
  - Latch the winner's index, op and data.
  - Register UART_ENB=1, with instruction from the op; blocking read issues 001 first. Go to ISSUE.
- ISSUE, non-blocking ops:
  - At the end of the cycle, capture wb_data into resp_data. Write returns 0.
  - Pulse req_ack[idx], set rr_ptr=idx, drive UART_ENB=0 and instruction=000, go to IDLE.
- ISSUE, blocking read:
  - If wb_data[0]=1: keep UART_ENB=1, set instruction=010, go to ISSUE_RD.
  - Otherwise: load mask_cnt[idx]=POLL_GAP, set rr_ptr=idx, drive UART_ENB=0, go to IDLE with no ack.
- ISSUE_RD: capture wb_data, pulse req_ack[idx], set rr_ptr=idx, drive UART_ENB=0, go to IDLE.
- Mask counters: each nonzero mask_cnt decrements by 1 per cycle and saturates at 0.
- Requester rules:
  - A requester holds its req_valid, op and wdata stable until req_ack.
  - Deasserting before grant withdraws the request.
  - After grant, the latched command completes regardless of req_valid.
- A wb_flag=0 with a read or available op is still treated as a result; resp_data takes wb_data as sampled.

## Timing
- The request is sampled at posedge N in IDLE.
- UART_ENB is high during cycle N+1. The controller acts on the negedge inside that cycle, and wb_data is sampled at posedge N+2.
- Latencies:
  - Available?, non-blocking read, write: req_ack high in cycle N+2.
  - Blocking read with data present: UART_ENB high in cycles N+1 and N+2, ack in cycle N+3.
  - Failed poll: the requester is re-eligible POLL_GAP cycles after leaving ISSUE.
- UART_ENB is never high for more than 2 consecutive cycles. It is never high in IDLE-entry cycles except on a new grant.
- Back-to-back: a new grant may be made in the ack cycle, but only to a different requester. Peak throughput is therefore one command every 2 cycles.

## Configuration
- Macro UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins; rr_ptr is not maintained. Poll masking still applies, so a polling requester 0 cannot starve the others.
- Not defined: round-robin as described under Operation.

## Test plan
- Write: req0 op=11, wdata=0x5A. Expected: UART_ENB=1, instruction=011 and write_value=0x5A for exactly one cycle; req_ack[0] two cycles after sampling; resp_data=0x00.
- Round-robin: req0..req3 all hold op=01 with the controller stubbed to answer 0x01. Expected: grants in order 1,2,3,0,1 with each ack at a 2-cycle spacing; no requester is granted twice in a row.
- Blocking read with data: req2 op=00, stub answers 0x01 then 0x41. Expected: instruction 001 then 010 on consecutive cycles; req_ack[2] with resp_data=0x41 in cycle N+3.
- Blocking read without data: req1 op=00, stub answers 0x00, req3 op=10 pending. Expected: no ack to req1; req3 acked next; req1 not re-issued for 8 cycles after the poll.
- Reset mid-command: assert reset in the ISSUE cycle. Expected: next cycle UART_ENB=0, instruction=000, req_ack=0, busy=0; no ack ever issued for the abandoned command.
- Fixed priority (macro defined): req0 and req3 both op=01. Expected: req0 is granted first, and again whenever it re-requests before req3 is granted.
